// File: rtl/regfile_dump_reader.sv
// Streams register-file entries START_REG..END_REG over a valid/ready port, one word per CAPTURE/SEND pair.
// Two cycles per word with out_ready high; a stalled word is held as a snapshot until it is accepted or aborted.
module regfile_dump_reader #(
  parameter int unsigned START_REG = 0,
  parameter int unsigned END_REG   = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_index,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  if (!((START_REG <= END_REG) && (END_REG <= 31))) begin : gParamCheck
    $error("regfile_dump_reader: START_REG <= END_REG <= 31 is required");
  end

  localparam logic [4:0] START_IDX = 5'(START_REG);
  localparam logic [4:0] END_IDX   = 5'(END_REG);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic        last;
    logic [4:0]  index;
    logic [31:0] data;
  } dumpWord_t;

  state_t    state;
  state_t    stateNext;
  logic [4:0] rdAddr;
  dumpWord_t word;
  logic      loadStart;
  logic      captureEn;
  logic      advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Abort is checked before the transfer so an aborted word never advances the address.
  always_comb begin
    stateNext = state;
    loadStart = 1'b0;
    captureEn = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          stateNext = CAPTURE;
          loadStart = 1'b1;
        end
      end
      CAPTURE: begin
        if (abort) begin
          stateNext = IDLE;
        end else begin
          stateNext = SEND;
          captureEn = 1'b1;
        end
      end
      SEND: begin
        if (abort) begin
          stateNext = IDLE;
        end else if (out_ready) begin
          if (word.last) begin
            stateNext = DONE;
          end else begin
            stateNext = CAPTURE;
            advance   = 1'b1;
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // The address only increments when the held word is not last, so it stops at END_REG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdAddr <= '0;
      word   <= '0;
    end else begin
      if (loadStart) begin
        rdAddr <= START_IDX;
      end else if (advance) begin
        rdAddr <= rdAddr + 5'd1;
      end
      if (captureEn) begin
        word <= '{last: (rdAddr == END_IDX), index: rdAddr, data: rd_data};
      end
    end
  end

  assign rd_addr   = rdAddr;
  assign out_valid = (state == SEND);
  assign out_data  = word.data;
  assign out_index = word.index;
  assign out_last  = word.last;
  assign busy      = (state == CAPTURE) || (state == SEND);
  assign done      = (state == DONE);

endmodule
